seed_seq_player: RTL and testbench

Consumer of the 32-bit game seed: latches `seed`, decodes it into a 16-step colour sequence (2 bits per step) and plays the first N steps on the LED outputs. It then checks the player's button presses against the same steps and reports pass or fail. It sits between the seed generator and the game FSM, which supplies the round length and reacts to `pass`/`fail`.

---
 rtl/seed_seq_player.sv | 176 +++++++++++++++++
 tb/tb_seed_seq_player.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seed_seq_player.sv
// seed_seq_player: latches a 32-bit seed and decodes it into 16 two-bit colour
// steps. On start it shows the first round_len steps on the LED, then checks
// the button presses against the same steps and pulses pass or fail.
// Optional feature macro: SEED_SEQ_TIMEOUT_EN. When it is defined, WAIT_IN
// gives up with a fail pulse after TIMEOUT_CYCLES cycles without a press.
// All outputs are registered. Their next values are derived from the
// next-state values, so they change on the same edge as the state.
module seed_seq_player #(
   parameter int ON_CYCLES      = 4,
   parameter int OFF_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        load_i,
   input  logic [31:0] seed_i,
   input  logic        start_i,
   input  logic [4:0]  round_len_i,
   input  logic        btn_valid_i,
   input  logic [1:0]  btn_i,
   output logic        led_en_o,
   output logic [1:0]  led_colour_o,
   output logic        busy_o,
   output logic        pass_o,
   output logic        fail_o
);

   localparam int PH_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   typedef enum logic [1:0] {IDLE, SHOW_ON, SHOW_OFF, WAIT_IN} state_e;

   state_e            state_q, state_d;
   logic [31:0]       seed_q, seed_d;
   logic [4:0]        len_q, len_d;
   logic [3:0]        idx_q, idx_d;
   logic [PH_W-1:0]   phase_q, phase_d;

   logic              led_en_q, led_en_d;
   logic [1:0]        led_colour_q, led_colour_d;
   logic              busy_q, busy_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;

   logic [1:0]        step_col;
   logic              last_step;
   logic              press, hit, miss, tmo_fire;

   assign step_col  = seed_q[{idx_q, 1'b0} +: 2];
   assign last_step = ({1'b0, idx_q} == (len_q - 5'd1));
   assign press     = (state_q == WAIT_IN) && btn_valid_i;
   assign hit       = press && (btn_i == step_col);
   assign miss      = press && (btn_i != step_col);

`ifdef SEED_SEQ_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q;

   // A press in the limit cycle wins over the timeout.
   assign tmo_fire = (state_q == WAIT_IN) && !btn_valid_i &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES));

   // Idle-wait counter: cleared outside WAIT_IN and on each accepted press.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)                         tmo_q <= '0;
      else if (state_q != WAIT_IN || hit)   tmo_q <= '0;
      else if (tmo_q != TMO_W'(TIMEOUT_CYCLES))
                                            tmo_q <= tmo_q + TMO_W'(1);
   end
`else
   assign tmo_fire = 1'b0;
`endif

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         seed_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         phase_q <= '0;
      end else begin
         state_q <= state_d;
         seed_q  <= seed_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         phase_q <= phase_d;
      end
   end

   // Next-state logic: playback timing and press checking.
   always_comb begin
      state_d = state_q;
      seed_d  = seed_q;
      len_d   = len_q;
      idx_d   = idx_q;
      phase_d = phase_q;
      case (state_q)
         IDLE: begin
            if (load_i) seed_d = seed_i;
            if (start_i && round_len_i != 5'd0) begin
               len_d   = (round_len_i > 5'd16) ? 5'd16 : round_len_i;
               idx_d   = '0;
               phase_d = '0;
               state_d = SHOW_ON;
            end
         end
         SHOW_ON: begin
            if (phase_q == PH_W'(ON_CYCLES - 1)) begin
               phase_d = '0;
               state_d = SHOW_OFF;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         SHOW_OFF: begin
            if (phase_q == PH_W'(OFF_CYCLES - 1)) begin
               phase_d = '0;
               if (last_step) begin
                  idx_d   = '0;
                  state_d = WAIT_IN;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = SHOW_ON;
               end
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         WAIT_IN: begin
            if (miss) begin
               state_d = IDLE;
            end else if (hit) begin
               if (last_step) state_d = IDLE;
               else           idx_d   = idx_q + 4'd1;
            end else if (tmo_fire) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: next output values from the next state, registered below.
   always_comb begin
      led_en_d     = (state_d == SHOW_ON);
      led_colour_d = led_en_d ? seed_d[{idx_d, 1'b0} +: 2] : 2'd0;
      busy_d       = (state_d != IDLE);
      pass_d       = hit && last_step;
      fail_d       = miss || tmo_fire;
   end

   // Output registers.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         led_en_q     <= 1'b0;
         led_colour_q <= 2'd0;
         busy_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         led_en_q     <= led_en_d;
         led_colour_q <= led_colour_d;
         busy_q       <= busy_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
      end
   end

   assign led_en_o     = led_en_q;
   assign led_colour_o = led_colour_q;
   assign busy_o       = busy_q;
   assign pass_o       = pass_q;
   assign fail_o       = fail_q;

endmodule

// File: tb/tb_seed_seq_player.sv
// Testbench for seed_seq_player with default timing (ON=4, OFF=2).
// The expected LED timeline and the press verdicts are computed from the
// round rules: step k = seed bits [2k+1:2k], lit for ON cycles, then OFF dark.
module tb_seed_seq_player;
   localparam int ON  = 4;
   localparam int OFF = 2;
   localparam int P   = ON + OFF;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        load_i;
   logic [31:0] seed_i;
   logic        start_i;
   logic [4:0]  round_len_i;
   logic        btn_valid_i;
   logic [1:0]  btn_i;
   logic        led_en_o;
   logic [1:0]  led_colour_o;
   logic        busy_o;
   logic        pass_o;
   logic        fail_o;

   int checks   = 0;
   int failures = 0;
   logic [1:0] pq[$];

   seed_seq_player dut (
      .clk_i(clk), .reset_i(reset_i), .load_i(load_i), .seed_i(seed_i),
      .start_i(start_i), .round_len_i(round_len_i), .btn_valid_i(btn_valid_i),
      .btn_i(btn_i), .led_en_o(led_en_o), .led_colour_o(led_colour_o),
      .busy_o(busy_o), .pass_o(pass_o), .fail_o(fail_o)
   );

   always #5 clk = ~clk;

   // {led_en, led_colour, busy, pass, fail}
   function automatic logic [5:0] obs();
      return {led_en_o, led_colour_o, busy_o, pass_o, fail_o};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Play one round: start, check every playback cycle, then feed pq.
   // b2b: leave right after the verdict cycle so the caller can start again.
   // tmo: send no presses and stop in the first WAIT_IN cycle.
   task automatic run_round(input logic [31:0] seed, input logic [4:0] len,
                            input bit b2b, input bit tmo);
      int L;
      logic [5:0] e;
      logic [1:0] st;
      bit done;
      L = (len > 16) ? 16 : int'(len);
      load_i = 1'b1; seed_i = seed; start_i = 1'b1; round_len_i = len;
      tick();
      load_i = 1'b0; start_i = 1'b0; seed_i = $urandom;
      if (L == 0) begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs() !== 6'b0) begin
               failures++;
               $display("FAIL len0_ignored cyc=%0d got=%b exp=%b", i, obs(), 6'b0);
            end
            tick();
         end
         return;
      end
      for (int c = 0; c < L * P; c++) begin
         st = seed[2 * (c / P) +: 2];
         e  = ((c % P) < ON) ? {1'b1, st, 3'b100} : 6'b000100;
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL playback len=%0d cyc=%0d got=%b exp=%b", L, c, obs(), e);
         end
         // load/start while busy must not disturb playback
         if (c == 2) begin
            load_i = 1'b1; seed_i = ~seed; start_i = 1'b1;
            round_len_i = 5'($urandom_range(1, 31));
         end
         // a press one cycle before WAIT_IN must be ignored
         if (c == L * P - 1) begin
            btn_valid_i = 1'b1; btn_i = seed[1:0] ^ 2'd1;
         end
         tick();
         load_i = 1'b0; start_i = 1'b0; btn_valid_i = 1'b0;
      end
      if (tmo) return;
      done = 1'b0;
      for (int i = 0; i < pq.size() && !done; i++) begin
         int gap;
         gap = (i == 0) ? 0 : int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            checks++;
            if (obs() !== 6'b000100) begin
               failures++;
               $display("FAIL wait_idle got=%b exp=%b", obs(), 6'b000100);
            end
            tick();
         end
         btn_valid_i = 1'b1; btn_i = pq[i];
         tick();
         btn_valid_i = 1'b0;
         st = seed[2 * i +: 2];
         if (pq[i] != st) begin
            e = 6'b000001; done = 1'b1;
         end else if (i == L - 1) begin
            e = 6'b000010; done = 1'b1;
         end else begin
            e = 6'b000100;
         end
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL press i=%0d btn=%0d got=%b exp=%b", i, pq[i], obs(), e);
         end
      end
      if (b2b) return;
      tick();
      checks++;
      if (obs() !== 6'b0) begin
         failures++;
         $display("FAIL pulse_single got=%b exp=%b", obs(), 6'b0);
      end
      btn_valid_i = 1'b1; btn_i = 2'($urandom);
      tick();
      btn_valid_i = 1'b0;
      checks++;
      if (obs() !== 6'b0) begin
         failures++;
         $display("FAIL press_after_end got=%b exp=%b", obs(), 6'b0);
      end
   endtask

   task automatic fill_correct(input logic [31:0] seed, input int L);
      pq.delete();
      for (int k = 0; k < L; k++) pq.push_back(seed[2 * k +: 2]);
   endtask

   task automatic test_reset();
      reset_i = 1'b0;
      load_i = 1'b0; seed_i = '0; start_i = 1'b0; round_len_i = '0;
      btn_valid_i = 1'b0; btn_i = '0;
      #12;
      checks++;
      if (obs() !== 6'b0) begin
         failures++;
         $display("FAIL reset_state got=%b exp=%b", obs(), 6'b0);
      end
      #3 reset_i = 1'b1;
      tick();
      // start a round, then reset asynchronously in the middle of SHOW_ON
      load_i = 1'b1; seed_i = 32'hE4E4E4E4; start_i = 1'b1; round_len_i = 5'd4;
      tick();
      load_i = 1'b0; start_i = 1'b0;
      tick();
      #2 reset_i = 1'b0;
      #1;
      checks++;
      if (obs() !== 6'b0) begin
         failures++;
         $display("FAIL async_reset got=%b exp=%b", obs(), 6'b0);
      end
      #1 reset_i = 1'b1;
      tick();
      fill_correct(32'hE4E4E4E4, 4);
      run_round(32'hE4E4E4E4, 5'd4, 1'b0, 1'b0);
   endtask

   task automatic test_pass();
      pq.delete();
      pq.push_back(2'd0); pq.push_back(2'd1); pq.push_back(2'd2); pq.push_back(2'd3);
      run_round(32'hE4E4E4E4, 5'd4, 1'b0, 1'b0);
   endtask

   task automatic test_fail();
      pq.delete();
      pq.push_back(2'd0); pq.push_back(2'd2);
      run_round(32'hE4E4E4E4, 5'd4, 1'b0, 1'b0);
   endtask

   task automatic test_clamp();
      fill_correct(32'hC0000000, 16);
      run_round(32'hC0000000, 5'd31, 1'b0, 1'b0);
      pq.delete();
      run_round(32'h12345678, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      fill_correct(32'h1B1B1B1B, 3);
      run_round(32'h1B1B1B1B, 5'd3, 1'b1, 1'b0);
      fill_correct(32'h9C9C9C9C, 2);
      run_round(32'h9C9C9C9C, 5'd2, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 10; r++) begin
         logic [31:0] s;
         logic [4:0]  len;
         int L;
         s   = $urandom;
         len = 5'($urandom_range(0, 31));
         L   = (len > 16) ? 16 : int'(len);
         fill_correct(s, L);
         if (L > 0 && $urandom_range(0, 1) == 1) begin
            int j;
            j = int'($urandom_range(0, L - 1));
            pq[j] = pq[j] ^ 2'($urandom_range(1, 3));
            while (pq.size() > j + 1) void'(pq.pop_back());
         end
         run_round(s, len, 1'b0, 1'b0);
      end
   endtask

`ifdef SEED_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      pq.delete();
      run_round(32'hE4E4E4E4, 5'd2, 1'b0, 1'b1);
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (obs() !== 6'b000100) begin
            failures++;
            $display("FAIL timeout_wait cyc=%0d got=%b exp=%b", i, obs(), 6'b000100);
         end
         tick();
      end
      tick();
      checks++;
      if (obs() !== 6'b000001) begin
         failures++;
         $display("FAIL timeout_fire got=%b exp=%b", obs(), 6'b000001);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_pass();
      test_fail();
      test_clamp();
      test_back_to_back();
      test_random();
`ifdef SEED_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
